// File: rtl/rv32c_pkg.sv
// rv32c_pkg: shared RV32 opcode, register and quadrant constants plus the expander result type.
package rv32c_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] LOAD_FP  = 7'b0000111;
    localparam logic [6:0] STORE_FP = 7'b0100111;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;
    localparam logic [1:0] Q3 = 2'b11;

    localparam logic [4:0] X0 = 5'd0;
    localparam logic [4:0] X1 = 5'd1;
    localparam logic [4:0] X2 = 5'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic        illegal;
    } expand_result_t;

endpackage

// File: rtl/rvc_expander.sv
// rvc_expander: combinational RV32C to RV32I expansion.
//   c   : 16-bit compressed encoding (quadrant 3 is not expanded here)
//   res : expanded word and illegal flag; illegal words carry the raw 16 bits zero-extended
module rvc_expander
    import rv32c_pkg::*;
#(
    parameter bit SUPPORT_F = 1'b0
)(
    input  logic [15:0]    c,
    output expand_result_t res
);

    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm_ci;
    logic [9:0]  ciw_imm, sp16_imm;
    logic [6:0]  lw_imm;
    logic [7:0]  ld_imm, lwsp_imm, swsp_imm;
    logic [8:0]  ldsp_imm, sdsp_imm;
    logic [20:1] j_imm;
    logic [12:1] b_imm;
    logic [2:0]  alu_f3;
    logic [31:0] inst;
    logic        ill;

    assign rd       = c[11:7];
    assign rs2      = c[6:2];
    assign rdp      = {2'b01, c[4:2]};
    assign rs1p     = {2'b01, c[9:7]};
    assign imm_ci   = {{7{c[12]}}, c[6:2]};
    assign ciw_imm  = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign sp16_imm = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    assign lw_imm   = {c[5], c[12:10], c[6], 2'b00};
    assign ld_imm   = {c[6:5], c[12:10], 3'b000};
    assign lwsp_imm = {c[3:2], c[12], c[6:4], 2'b00};
    assign ldsp_imm = {c[4:2], c[12], c[6:5], 3'b000};
    assign swsp_imm = {c[8:7], c[12:9], 2'b00};
    assign sdsp_imm = {c[9:7], c[12:10], 3'b000};
    assign j_imm    = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    assign b_imm    = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
    assign alu_f3   = c[6:5] == 2'b00 ? 3'b000 : c[6:5] == 2'b01 ? 3'b100 : c[6:5] == 2'b10 ? 3'b110 : 3'b111;

    always_comb begin
        inst = {16'h0000, c};
        ill  = 1'b0;
        case ({c[15:13], c[1:0]})
            {3'b000, Q0}: begin
                inst = {2'b00, ciw_imm, X2, 3'b000, rdp, OP_IMM};
                ill  = ciw_imm == 10'd0;
            end
            {3'b001, Q0}: begin
                inst = {4'b0000, ld_imm, rs1p, 3'b011, rdp, LOAD_FP};
                ill  = !SUPPORT_F;
            end
            {3'b010, Q0}: inst = {5'b00000, lw_imm, rs1p, 3'b010, rdp, LOAD};
            {3'b011, Q0}: begin
                inst = {5'b00000, lw_imm, rs1p, 3'b010, rdp, LOAD_FP};
                ill  = !SUPPORT_F;
            end
            {3'b101, Q0}: begin
                inst = {4'b0000, ld_imm[7:5], rdp, rs1p, 3'b011, ld_imm[4:0], STORE_FP};
                ill  = !SUPPORT_F;
            end
            {3'b110, Q0}: inst = {5'b00000, lw_imm[6:5], rdp, rs1p, 3'b010, lw_imm[4:0], STORE};
            {3'b111, Q0}: begin
                inst = {5'b00000, lw_imm[6:5], rdp, rs1p, 3'b010, lw_imm[4:0], STORE_FP};
                ill  = !SUPPORT_F;
            end
            {3'b000, Q1}: inst = {imm_ci, rd, 3'b000, rd, OP_IMM};
            {3'b001, Q1}: inst = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12], X1, JAL};
            {3'b010, Q1}: inst = {imm_ci, X0, 3'b000, rd, OP_IMM};
            {3'b011, Q1}: begin
                // rd=x2 selects C.ADDI16SP, any other rd is C.LUI
                inst = rd == X2 ? {{2{c[12]}}, sp16_imm, X2, 3'b000, X2, OP_IMM}
                                : {{14{c[12]}}, c[12], c[6:2], rd, LUI};
                ill  = rd == X2 ? sp16_imm == 10'd0 : {c[12], c[6:2]} == 6'd0;
            end
            {3'b100, Q1}: begin
                // c[12] is shamt[5] for the shifts and selects the RV64-only forms in the ALU group
                inst = !c[11] ? {1'b0, c[10], 5'b00000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM}
                     : !c[10] ? {imm_ci, rs1p, 3'b111, rs1p, OP_IMM}
                     : {1'b0, c[6:5] == 2'b00, 5'b00000, rdp, rs1p, alu_f3, rs1p, OP};
                ill  = c[11] ? c[10] & c[12] : c[12];
            end
            {3'b101, Q1}: inst = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12], X0, JAL};
            {3'b110, Q1}: inst = {b_imm[12], b_imm[10:5], X0, rs1p, 3'b000, b_imm[4:1], b_imm[11], BRANCH};
            {3'b111, Q1}: inst = {b_imm[12], b_imm[10:5], X0, rs1p, 3'b001, b_imm[4:1], b_imm[11], BRANCH};
            {3'b000, Q2}: begin
                inst = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
                ill  = c[12];
            end
            {3'b001, Q2}: begin
                inst = {3'b000, ldsp_imm, X2, 3'b011, rd, LOAD_FP};
                ill  = !SUPPORT_F;
            end
            {3'b010, Q2}: begin
                inst = {4'b0000, lwsp_imm, X2, 3'b010, rd, LOAD};
                ill  = rd == X0;
            end
            {3'b011, Q2}: begin
                inst = {4'b0000, lwsp_imm, X2, 3'b010, rd, LOAD_FP};
                ill  = !SUPPORT_F;
            end
            {3'b100, Q2}: begin
                // c[12]=0: C.JR / C.MV; c[12]=1: C.EBREAK / C.JALR / C.ADD
                inst = !c[12] ? (rs2 == X0 ? {12'd0, rd, 3'b000, X0, JALR} : {7'd0, rs2, X0, 3'b000, rd, OP})
                     : rs2 != X0 ? {7'd0, rs2, rd, 3'b000, rd, OP}
                     : rd == X0 ? {12'd1, X0, 3'b000, X0, SYSTEM}
                     : {12'd0, rd, 3'b000, X1, JALR};
                ill  = !c[12] & rs2 == X0 & rd == X0;
            end
            {3'b101, Q2}: begin
                inst = {3'b000, sdsp_imm[8:5], rs2, X2, 3'b011, sdsp_imm[4:0], STORE_FP};
                ill  = !SUPPORT_F;
            end
            {3'b110, Q2}: inst = {4'b0000, swsp_imm[7:5], rs2, X2, 3'b010, swsp_imm[4:0], STORE};
            {3'b111, Q2}: begin
                inst = {4'b0000, swsp_imm[7:5], rs2, X2, 3'b010, swsp_imm[4:0], STORE_FP};
                ill  = !SUPPORT_F;
            end
            default: ill = 1'b1;
        endcase
    end

    assign res.inst    = ill ? {16'h0000, c} : inst;
    assign res.illegal = ill;

endmodule

// File: rtl/rvc_expand_stage.sv
// rvc_expand_stage: RV32C expansion stage with a 2-entry skid buffer between fetch and decode.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_inst/in_pc : fetch side handshake and instruction
//   flush                        : drop all held entries and the beat offered this cycle
//   out_valid/out_ready          : decode side handshake
//   out_inst/out_pc              : expanded instruction and its PC
//   out_compressed/out_illegal   : original length was 16 bits / illegal compressed encoding
module rvc_expand_stage
    import rv32c_pkg::*;
#(
    parameter bit SUPPORT_F = 1'b0,
    parameter int PC_W      = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic            out_compressed,
    output logic            out_illegal
);

    // entry layout: {inst, pc, compressed, illegal}
    localparam int EW = 32 + PC_W + 2;

    expand_result_t exp_res;
    logic           in_comp, acc, pop;
    logic [EW-1:0]  in_e, main_d, main_q, skid_d, skid_q;
    logic           main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;

    rvc_expander #(.SUPPORT_F(SUPPORT_F)) u_expander (
        .c   (in_inst[15:0]),
        .res (exp_res)
    );

    assign in_comp = in_inst[1:0] != 2'b11;
    assign in_e    = {in_comp ? exp_res.inst : in_inst, in_pc, in_comp, in_comp & exp_res.illegal};
    assign acc     = in_valid & ~skid_valid_q & ~flush;
    assign pop     = ~main_valid_q | out_ready;

    // in_ready is low whenever the skid is full, so an accept only ever lands
    // in main (main free, skid empty) or in the skid (main held)
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            main_valid_d = skid_valid_q | acc;
            main_d       = skid_valid_q ? skid_q : acc ? in_e : main_q;
            skid_valid_d = 1'b0;
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_d       = in_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign {out_inst, out_pc, out_compressed, out_illegal} = main_q;

endmodule

// File: tb/tb_rvc_expand_stage.sv
// tb_rvc_expand_stage: scoreboard bench for the RV32C expansion stage.
module tb_rvc_expand_stage;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] e;
        logic        il;
    } vec_t;

    localparam int NV = 21;

    vec_t vecs [0:NV-1] = '{
        '{32'h0000_0085, 32'h0010_8093, 1'b0},
        '{32'h0000_852E, 32'h00B0_0533, 1'b0},
        '{32'h0000_9002, 32'h0010_0073, 1'b0},
        '{32'h0000_0013, 32'h0000_0013, 1'b0},
        '{32'h0000_0000, 32'h0000_0000, 1'b1},
        '{32'h0000_4002, 32'h0000_4002, 1'b1},
        '{32'h0000_40C0, 32'h0044_A403, 1'b0},
        '{32'h0000_BFFD, 32'hFFFF_F06F, 1'b0},
        '{32'h0000_C401, 32'h0004_0463, 1'b0},
        '{32'h0000_6085, 32'h0000_10B7, 1'b0},
        '{32'h0000_6101, 32'h0000_6101, 1'b1},
        '{32'h0000_1082, 32'h0000_1082, 1'b1},
        '{32'h0000_8C05, 32'h4094_0433, 1'b0},
        '{32'h0000_9C05, 32'h0000_9C05, 1'b1},
        '{32'h0000_60C0, 32'h0000_60C0, 1'b1},
        '{32'h0000_C206, 32'h0011_2223, 1'b0},
        '{32'h0000_9082, 32'h0000_80E7, 1'b0},
        '{32'h0000_0040, 32'h0041_0413, 1'b0},
        '{32'h0000_52FD, 32'hFFF0_0293, 1'b0},
        '{32'hFFF0_0293, 32'hFFF0_0293, 1'b0},
        '{32'hDEAD_852E, 32'h00B0_0533, 1'b0}
    };

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] in_inst = '0, in_pc = '0;
    logic        in_ready, out_valid, out_compressed, out_illegal;
    logic [31:0] out_inst, out_pc;
    int          tests = 0, fails = 0;
    logic [65:0] exp_q [$];

    always #5 clk = ~clk;

    rvc_expand_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_compressed (out_compressed),
        .out_illegal    (out_illegal)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // monitor: held outputs must match the queue head, consumed ones pop it
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got inst=%h pc=%h, want no output", out_inst, out_pc);
            end else begin
                chk(out_ready ? "out" : "held", {out_inst, out_pc, out_compressed, out_illegal}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] e, input logic il);
        int n = 0;
        in_valid = 1'b1;
        in_inst  = i;
        in_pc    = pc;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout pc=%h: in_ready=0, want 1", pc);
        end else begin
            exp_q.push_back({e, pc, i[1:0] != 2'b11, il});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d beats pending, want 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {out_inst, out_pc, out_compressed, out_illegal}, 66'h0);
        chk("reset_hs", {64'h0, out_valid, in_ready}, {64'h0, 2'b01});
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < NV; k++)
            send(vecs[k].i, 32'h100 + 32'(4 * k), vecs[k].e, vecs[k].il);
        wait_empty("drain_vectors");

        out_ready = 1'b0;
        send(32'h0000_0085, 32'h0, 32'h0010_8093, 1'b0);
        send(32'h0000_852E, 32'h2, 32'h00B0_0533, 1'b0);
        @(negedge clk);
        chk("bp_hs", {64'h0, out_valid, in_ready}, {64'h0, 2'b10});
        fork
            send(32'h0000_0013, 32'h6, 32'h0000_0013, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty("drain_backpressure");

        out_ready = 1'b0;
        send(32'h0000_0085, 32'h300, 32'h0010_8093, 1'b0);
        send(32'h0000_9002, 32'h302, 32'h0010_0073, 1'b0);
        in_valid = 1'b1;
        in_inst  = 32'h0000_852E;
        in_pc    = 32'h304;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_hs", {64'h0, out_valid, in_ready}, {64'h0, 2'b01});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0000_0040, 32'h200, 32'h0041_0413, 1'b0);
        wait_empty("drain_flush");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_hs", {64'h0, out_valid, in_ready}, {64'h0, 2'b01});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
